executor_movimentos: RTL

- Move-sequencing stage between the move RAM and the servo manager.
- After solution upload, walks the move RAM from address 0 and issues each 3-bit move code to gerenciador_servos with an iniciar/pronto handshake.
- Stops at end marker 3'b000. Supports pause and abort, and flags a servo timeout or an address overflow.
- Replaces ad-hoc address stepping in the control unit; owns the read address whenever the datapath selects read mode.

---
 rtl/rubiks_polibot_pkg.sv | 27 ++
 rtl/timeout_contador.sv | 36 +++
 rtl/executor_movimentos.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/rubiks_polibot_pkg.sv
// Shared definitions for the move pipeline: move codes, executor state
// encodings and the default servo timeout.
package rubiks_polibot_pkg;

  localparam int TIMEOUT_CICLOS_PADRAO = 150000000;

  localparam logic [2:0] MOV_FIM     = 3'b000;
  localparam logic [2:0] MOV_U       = 3'b001;
  localparam logic [2:0] MOV_U_LINHA = 3'b010;
  localparam logic [2:0] MOV_F       = 3'b011;
  localparam logic [2:0] MOV_F_LINHA = 3'b100;
  localparam logic [2:0] MOV_R       = 3'b101;
  localparam logic [2:0] MOV_R_LINHA = 3'b110;
  localparam logic [2:0] MOV_VIRA    = 3'b111;

  typedef enum logic [3:0] {
    INICIAL = 4'd0,
    LE      = 4'd1,
    AVALIA  = 4'd2,
    ACIONA  = 4'd3,
    ESPERA  = 4'd4,
    PROXIMO = 4'd5,
    PAUSADO = 4'd6,
    FIM     = 4'd7
  } estado_t;

endpackage

// File: rtl/timeout_contador.sv
// Servo watchdog: counts enabled cycles after a clear and flags the
// terminal count TIMEOUT_CICLOS-1; saturates there.
module timeout_contador
  import rubiks_polibot_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO,
  parameter int N_TIMEOUT      = 28
) (
  input  logic clock,
  input  logic reset,
  input  logic limpa,
  input  logic conta,
  output logic fim_contagem
);

  localparam logic [N_TIMEOUT-1:0] ULTIMO = N_TIMEOUT'(TIMEOUT_CICLOS - 1);
  localparam logic [N_TIMEOUT-1:0] UM     = N_TIMEOUT'(1);

  logic [N_TIMEOUT-1:0] contagem_r;

  // cycle counter with clear priority over enable
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      contagem_r <= '0;
    end else if (limpa) begin
      contagem_r <= '0;
    end else if (conta && (contagem_r != ULTIMO)) begin
      contagem_r <= contagem_r + UM;
    end else begin
      contagem_r <= contagem_r;
    end
  end

  assign fim_contagem = (contagem_r == ULTIMO);

endmodule

// File: rtl/executor_movimentos.sv
// Walks the move RAM from address 0, handing each move code to the servo
// manager with an aciona/servo_pronto handshake; supports pause and abort.
module executor_movimentos
  import rubiks_polibot_pkg::*;
#(
  parameter int N_ADDR         = 9,
  parameter int MAX_MOV        = 480,
  parameter int S_MOV          = 3,
  parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO,
  parameter int N_TIMEOUT      = 28
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              pausar,
  input  logic              abortar,
  input  logic [S_MOV-1:0]  mov_dado,
  input  logic              servo_pronto,
  output logic [N_ADDR-1:0] mov_addr,
  output logic              aciona,
  output logic [S_MOV-1:0]  movimento,
  output logic              pronto,
  output logic              pausado,
  output logic              erro_timeout,
  output logic              erro_overflow,
  output logic              abortado,
  output logic [N_ADDR-1:0] total_movimentos,
  output logic [3:0]        db_estado
);

  localparam logic [N_ADDR-1:0] ULTIMO_ADDR = N_ADDR'(MAX_MOV - 1);
  localparam logic [N_ADDR-1:0] UM_ADDR     = N_ADDR'(1);
  localparam logic [S_MOV-1:0]  COD_FIM     = S_MOV'(MOV_FIM);

  estado_t           estado_r, estado_s;
  logic [N_ADDR-1:0] addr_r, addr_s, total_r, total_s;
  logic [S_MOV-1:0]  mov_r, mov_s;
  logic              to_r, to_s, ov_r, ov_s, ab_r, ab_s, latch_r, latch_s;
  logic              limpa_s, fim_to_s;

  timeout_contador #(
    .TIMEOUT_CICLOS (TIMEOUT_CICLOS),
    .N_TIMEOUT      (N_TIMEOUT)
  ) u_timeout (
    .clock        (clock),
    .reset        (reset),
    .limpa        (limpa_s),
    .conta        (estado_r == ESPERA),
    .fim_contagem (fim_to_s)
  );

  // state and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_r <= INICIAL;
      addr_r   <= '0;
      total_r  <= '0;
      mov_r    <= '0;
      to_r     <= 1'b0;
      ov_r     <= 1'b0;
      ab_r     <= 1'b0;
      latch_r  <= 1'b0;
    end else begin
      estado_r <= estado_s;
      addr_r   <= addr_s;
      total_r  <= total_s;
      mov_r    <= mov_s;
      to_r     <= to_s;
      ov_r     <= ov_s;
      ab_r     <= ab_s;
      latch_r  <= latch_s;
    end
  end

  // next-state and datapath update
  always_comb begin
    estado_s = estado_r;
    addr_s   = addr_r;
    total_s  = total_r;
    mov_s    = mov_r;
    to_s     = to_r;
    ov_s     = ov_r;
    ab_s     = ab_r;
    latch_s  = latch_r;
    limpa_s  = 1'b0;
    // abort is only remembered while a run is in flight
    if (abortar && (estado_r != INICIAL) && (estado_r != FIM)) begin
      latch_s = 1'b1;
    end else begin
      latch_s = latch_r;
    end
    case (estado_r)
      INICIAL, FIM: begin
        if (iniciar) begin
          addr_s   = '0;
          total_s  = '0;
          mov_s    = '0;
          to_s     = 1'b0;
          ov_s     = 1'b0;
          ab_s     = 1'b0;
          latch_s  = 1'b0;
          limpa_s  = 1'b1;
          estado_s = LE;
        end else begin
          estado_s = estado_r;
        end
      end
      LE: estado_s = AVALIA;
      AVALIA: begin
        if (latch_r) begin
          ab_s     = 1'b1;
          estado_s = FIM;
        end else if (mov_dado == COD_FIM) begin
          estado_s = FIM;
        end else begin
          mov_s    = mov_dado;
          limpa_s  = 1'b1;
          estado_s = ACIONA;
        end
      end
      ACIONA: estado_s = ESPERA;
      ESPERA: begin
        if (servo_pronto) begin
          estado_s = PROXIMO;
        end else if (fim_to_s) begin
          to_s     = 1'b1;
          estado_s = FIM;
        end else begin
          estado_s = ESPERA;
        end
      end
      PROXIMO: begin
        total_s = total_r + UM_ADDR;
        if (addr_r == ULTIMO_ADDR) begin
          ov_s     = 1'b1;
          estado_s = FIM;
        end else begin
          addr_s = addr_r + UM_ADDR;
          if (latch_r) begin
            ab_s     = 1'b1;
            estado_s = FIM;
          end else if (pausar) begin
            estado_s = PAUSADO;
          end else begin
            estado_s = LE;
          end
        end
      end
      PAUSADO: begin
        if (abortar || latch_r) begin
          ab_s     = 1'b1;
          estado_s = FIM;
        end else if (!pausar) begin
          estado_s = LE;
        end else begin
          estado_s = PAUSADO;
        end
      end
      default: estado_s = INICIAL;
    endcase
  end

  assign mov_addr         = addr_r;
  assign movimento        = mov_r;
  assign total_movimentos = total_r;
  assign erro_timeout     = to_r;
  assign erro_overflow    = ov_r;
  assign abortado         = ab_r;
  assign aciona           = (estado_r == ACIONA);
  assign pronto           = (estado_r == FIM);
  assign pausado          = (estado_r == PAUSADO);
  assign db_estado        = estado_r;

endmodule
